encryption_top: RTL and testbench

//  Iterative AES-128 encryption core: one round per clock, on-the-fly key expansion.

---
 rtl/encryption_top.sv | 196 +++++++++++++++++++
 tb/tb_encryption_top.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encryption_top.sv
// Iterative AES-128 encryption core, one round per clock with on-the-fly key expansion.
// Optional port last_round_key is enabled by defining AES_ENC_LAST_KEY_EN.

module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the FIPS-197 affine transform
  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

  assign w_x2   = gf_mul(i_byte, i_byte);
  assign w_x3   = gf_mul(w_x2, i_byte);
  assign w_x6   = gf_mul(w_x3, w_x3);
  assign w_x12  = gf_mul(w_x6, w_x6);
  assign w_x15  = gf_mul(w_x12, w_x3);
  assign w_x30  = gf_mul(w_x15, w_x15);
  assign w_x60  = gf_mul(w_x30, w_x30);
  assign w_x120 = gf_mul(w_x60, w_x60);
  assign w_x240 = gf_mul(w_x120, w_x120);
  assign w_x252 = gf_mul(w_x240, w_x12);
  assign w_inv  = gf_mul(w_x252, w_x2);

  assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module encryption_top #(
  parameter int KEY_W = 128,
  parameter int BLK_W = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [BLK_W-1:0] plaintext,
  output logic [BLK_W-1:0] ciphertext,
  output logic             done
`ifdef AES_ENC_LAST_KEY_EN
  ,
  output logic [KEY_W-1:0] last_round_key
`endif
);
  localparam logic [3:0] LP_NR = 4'd10;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_fsm, w_fsm_nxt;
  logic             r_rst_meta, r_rst_sync;
  logic [BLK_W-1:0] r_state;
  logic [KEY_W-1:0] r_rk;
  logic [7:0]       r_rcon;
  logic [3:0]       r_rnd;
  logic             w_load, w_last, w_step;

  logic [7:0]       w_sb [16];
  logic [7:0]       w_sr [16];
  logic [7:0]       w_mc [16];
  logic [127:0]     w_round_out;
  logic [31:0]      w_rot, w_ksub, w_t, w_nk0, w_nk1, w_nk2, w_nk3;
  logic [127:0]     w_nk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Asserts asynchronously, releases on clk so no flop sees a partial reset edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 16; g++) begin : g_data_sbox
      sbox u_sbox (.i_byte(r_state[127-8*g -: 8]), .o_byte(w_sb[g]));
    end
    for (g = 0; g < 4; g++) begin : g_key_sbox
      sbox u_sbox (.i_byte(w_rot[31-8*g -: 8]), .o_byte(w_ksub[31-8*g -: 8]));
    end
  endgenerate

  assign w_rot = {r_rk[23:0], r_rk[31:24]};
  assign w_t   = w_ksub ^ {r_rcon, 24'h0};
  assign w_nk0 = r_rk[127:96] ^ w_t;
  assign w_nk1 = r_rk[95:64]  ^ w_nk0;
  assign w_nk2 = r_rk[63:32]  ^ w_nk1;
  assign w_nk3 = r_rk[31:0]   ^ w_nk2;
  assign w_nk  = {w_nk0, w_nk1, w_nk2, w_nk3};

  // Byte i sits at row i%4, column i/4
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_mc[4*c]   = xt(w_sr[4*c]) ^ xt(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+1] = w_sr[4*c] ^ xt(w_sr[4*c+1]) ^ xt(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xt(w_sr[4*c+2]) ^ xt(w_sr[4*c+3]) ^ w_sr[4*c+3];
      w_mc[4*c+3] = xt(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xt(w_sr[4*c+3]);
    end
  end

  always_comb begin
    w_round_out = '0;
    for (int i = 0; i < 16; i++) begin
      w_round_out[127-8*i -: 8] = ((r_rnd == LP_NR) ? w_sr[i] : w_mc[i]) ^ w_nk[127-8*i -: 8];
    end
  end

  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) r_fsm <= IDLE;
    else             r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_load    = 1'b0;
    w_last    = 1'b0;
    w_step    = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (start) begin
          w_fsm_nxt = BUSY;
          w_load    = 1'b1;
        end
      end
      BUSY: begin
        if (r_rnd == 4'd0 || r_rnd > LP_NR) begin
          w_fsm_nxt = IDLE;
        end else begin
          w_step = 1'b1;
          if (r_rnd == LP_NR) begin
            w_fsm_nxt = IDLE;
            w_last    = 1'b1;
          end
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_state    <= '0;
      r_rk       <= '0;
      r_rcon     <= 8'h00;
      r_rnd      <= 4'd0;
      ciphertext <= '0;
      done       <= 1'b0;
`ifdef AES_ENC_LAST_KEY_EN
      last_round_key <= '0;
`endif
    end else begin
      done <= w_last;
      if (w_load) begin
        r_state <= plaintext ^ key;
        r_rk    <= key;
        r_rcon  <= 8'h01;
        r_rnd   <= 4'd1;
      end else if (w_step) begin
        r_state <= w_round_out;
        r_rk    <= w_nk;
        r_rcon  <= xt(r_rcon);
        if (!w_last) r_rnd <= r_rnd + 4'd1;
      end
      if (w_last) begin
        ciphertext <= w_round_out;
`ifdef AES_ENC_LAST_KEY_EN
        last_round_key <= w_nk;
`endif
      end
    end
  end
endmodule

// File: tb/tb_encryption_top.sv
// Randomized self-checking bench for encryption_top against a byte-array AES model.
// Checks last_round_key when AES_ENC_LAST_KEY_EN is defined.

module tb_encryption_top;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [127:0] key, plaintext, ciphertext;
  logic         done;
`ifdef AES_ENC_LAST_KEY_EN
  logic [127:0] last_round_key;
`endif

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] L1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] L2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_t [256];
  logic [7:0]   isbox_t [256];
  logic [7:0]   rcon_t [11];
  logic [31:0]  mw [44];
  logic [127:0] last_exp;
  logic [127:0] got;

  always #5 clk = ~clk;

  encryption_top dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .key        (key),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .done       (done)
`ifdef AES_ENC_LAST_KEY_EN
    ,
    .last_round_key (last_round_key)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ aa;
      aa = aa << 1;
      if (aa > 255) aa = aa ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  function automatic void build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
    rcon_t[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rcon_t[i] = gmul(rcon_t[i-1], 8'h02);
  endfunction

  function automatic void expand(input logic [127:0] k);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) mw[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = mw[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon_t[i/4], 24'h0};
      end
      mw[i] = mw[i-4] ^ t;
    end
  endfunction

  function automatic logic [7:0] rkb(input int r, input int i);
    logic [31:0] w;
    w = mw[4*r + i/4];
    return w[31-8*(i%4) -: 8];
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    expand(k);
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rkb(0, i);
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 10) begin
          s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
          s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkb(rd, i);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    expand(k);
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rkb(10, i);
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*((c+r)%4)] = isbox_t[s[r+4*c]];
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ rkb(rd, i);
      for (int c = 0; c < 4; c++) begin
        if (rd > 0) begin
          s[4*c]   = gmul(t[4*c],14) ^ gmul(t[4*c+1],11) ^ gmul(t[4*c+2],13) ^ gmul(t[4*c+3],9);
          s[4*c+1] = gmul(t[4*c],9)  ^ gmul(t[4*c+1],14) ^ gmul(t[4*c+2],11) ^ gmul(t[4*c+3],13);
          s[4*c+2] = gmul(t[4*c],13) ^ gmul(t[4*c+1],9)  ^ gmul(t[4*c+2],14) ^ gmul(t[4*c+3],11);
          s[4*c+3] = gmul(t[4*c],11) ^ gmul(t[4*c+1],13) ^ gmul(t[4*c+2],9)  ^ gmul(t[4*c+3],14);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One isolated operation; inputs are scrambled at cycle 3 to prove they were latched
  task automatic run_op(input logic [127:0] k, input logic [127:0] p, input string tag,
                        output logic [127:0] res);
    logic [127:0] exp, exp_lk, cap;
    int done_at, n_pulse;
    bit stable, held;
    exp    = model_enc(k, p);
    exp_lk = {mw[40], mw[41], mw[42], mw[43]};
    @(negedge clk);
    key = k; plaintext = p; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_at = -1; n_pulse = 0; stable = 1'b1; held = 1'b1; cap = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 3) begin key = rnd128(); plaintext = rnd128(); end
      if (done) begin n_pulse++; done_at = c; end
      if (c < 11 && ciphertext !== last_exp) stable = 1'b0;
      if (c == 11) cap = ciphertext;
      if (c > 11 && ciphertext !== exp) held = 1'b0;
    end
    chk({tag, "_ct"}, cap, exp);
    chk({tag, "_done_cycle"}, 128'(done_at), 128'(11));
    chk({tag, "_done_pulses"}, 128'(n_pulse), 128'(1));
    chk({tag, "_ct_stable_before"}, 128'(stable), 128'(1));
    chk({tag, "_ct_held_after"}, 128'(held), 128'(1));
`ifdef AES_ENC_LAST_KEY_EN
    chk({tag, "_last_key"}, last_round_key, exp_lk);
`endif
    last_exp = exp;
    res = cap;
  endtask

  task automatic back_to_back();
    logic [127:0] k1, p1, k2, p2, e1, e2;
    int n_pulse, first_at, second_at;
    k1 = rnd128(); p1 = rnd128(); k2 = rnd128(); p2 = rnd128();
    e1 = model_enc(k1, p1);
    e2 = model_enc(k2, p2);
    n_pulse = 0; first_at = -1; second_at = -1;
    @(negedge clk);
    key = k1; plaintext = p1; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (c == 3) begin key = k2; plaintext = p2; end
      if (c == 12) start = 1'b0;
      if (done) begin
        n_pulse++;
        if (first_at < 0) first_at = c; else second_at = c;
      end
      if (c == 11) chk("b2b_first_ct", ciphertext, e1);
      if (c == 22) chk("b2b_second_ct", ciphertext, e2);
    end
    chk("b2b_pulses", 128'(n_pulse), 128'(2));
    chk("b2b_spacing", 128'(second_at - first_at), 128'(11));
    last_exp = e2;
  endtask

  task automatic reset_mid_op();
    int n_pulse = 0;
    @(negedge clk);
    key = K2; plaintext = P2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_ct", ciphertext, 128'h0);
    chk("midrst_done", 128'(done), 128'h0);
`ifdef AES_ENC_LAST_KEY_EN
    chk("midrst_last_key", last_round_key, 128'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) n_pulse++;
    end
    chk("midrst_no_done", 128'(n_pulse), 128'h0);
    chk("midrst_ct_after", ciphertext, 128'h0);
    last_exp = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();
    reset_n = 1'b0; start = 1'b0; key = '0; plaintext = '0; last_exp = '0;
    repeat (3) @(negedge clk);
    chk("rst_ct", ciphertext, 128'h0);
    chk("rst_done", 128'(done), 128'h0);
`ifdef AES_ENC_LAST_KEY_EN
    chk("rst_last_key", last_round_key, 128'h0);
`endif
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    run_op(K1, P1, "v1", got);
    chk("v1_known_ct", got, C1);
`ifdef AES_ENC_LAST_KEY_EN
    chk("v1_known_last_key", last_round_key, L1);
`endif
    run_op(K2, P2, "v2", got);
    chk("v2_known_ct", got, C2);
`ifdef AES_ENC_LAST_KEY_EN
    chk("v2_known_last_key", last_round_key, L2);
`endif
    chk("v2_round_trip", model_dec(got, K2), P2);

    for (int n = 0; n < 6; n++) run_op(rnd128(), rnd128(), $sformatf("rand%0d", n), got);

    back_to_back();
    repeat (3) @(negedge clk);

    reset_mid_op();
    repeat (3) @(negedge clk);
    run_op(K1, P1, "post_rst_v1", got);
    chk("post_rst_known_ct", got, C1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
